// File: rtl/ex_mem_reg.sv
// -----------------------------------------------------------------------------
// ex_mem_reg -- EX/MEM pipeline register
//
// Carries the GPR write-back fields and HI/LO write fields from the execute
// stage to the memory stage. It also holds the multi-cycle scratch state
// (partial product and cycle count), which is looped back to EX.
//
// Each clock edge does one of three things:
//   Advance (stall[4]=0, stall[3]=0) : mem_* <= ex_*,     scratch <= 0
//   Bubble  (stall[4]=0, stall[3]=1) : mem_* <= 0 (NOP), scratch <= hilo_i/cnt_i
//   Hold    (stall[4]=1)             : every output keeps its value
// Only bits 3 and 4 of the stall vector are used.
//
// Optional build macro:
//   EX_MEM_FLUSH_EN : adds the 'flush' input. flush=1 at an edge writes NOP
//                     values to mem_* and clears the scratch. It overrides
//                     every stall case.
//
// Ports:
//   clk        in   1  pipeline clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   stall      in   6  pipeline stall vector (bit3 = EX, bit4 = MEM)
//   flush      in   1  pipeline flush (only with EX_MEM_FLUSH_EN)
//   ex_wd      in   5  GPR write address from EX
//   ex_wreg    in   1  GPR write enable from EX
//   ex_wdata   in  32  GPR write data from EX
//   ex_hi      in  32  HI write value from EX
//   ex_lo      in  32  LO write value from EX
//   ex_whilo   in   1  HI/LO write enable from EX
//   hilo_i     in  64  multi-cycle partial product from EX
//   cnt_i      in   2  multi-cycle cycle count from EX
//   mem_wd     out  5  registered GPR write address
//   mem_wreg   out  1  registered GPR write enable
//   mem_wdata  out 32  registered GPR write data
//   mem_hi     out 32  registered HI value
//   mem_lo     out 32  registered LO value
//   mem_whilo  out  1  registered HI/LO write enable
//   hilo_o     out 64  registered partial product, looped back to EX
//   cnt_o      out  2  registered cycle count, looped back to EX
// -----------------------------------------------------------------------------
module ex_mem_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
`ifdef EX_MEM_FLUSH_EN
  input  logic        flush,
`endif
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        ex_whilo,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic [63:0] hilo_o,
  output logic [1:0]  cnt_o
);

  // What the register does at the next edge.
  typedef enum logic [1:0] {
    MODE_ADVANCE = 2'd0,
    MODE_BUBBLE  = 2'd1,
    MODE_HOLD    = 2'd2,
    MODE_FLUSH   = 2'd3
  } mode_e;

  // Everything the stage register holds.
  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } stage_t;

  mode_e  w_mode;
  stage_t w_next;
  stage_t r_stage;

  // The stall controller only drives bits 3 and 4. The other bits are
  // gathered here so it is clear they are ignored on purpose.
  logic   w_unused_stall;
  assign w_unused_stall = ^{stall[5], stall[2:0]};

  // Mode decode. MEM stalled wins over EX stalled. The combination
  // stall[4]=1 / stall[3]=0 therefore holds, so a stalled MEM instruction is
  // never overwritten.
  always_comb begin
    w_mode = MODE_ADVANCE;
    if (stall[4]) begin
      w_mode = MODE_HOLD;
    end else if (stall[3]) begin
      w_mode = MODE_BUBBLE;
    end
`ifdef EX_MEM_FLUSH_EN
    if (flush) begin
      w_mode = MODE_FLUSH;
    end
`endif
  end

  // Next-state selection.
  // NOTE: every field of w_next gets a default before the case statement, so
  // no path through this block can leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_stage;
    unique case (w_mode)
      MODE_ADVANCE: begin
        w_next.wd    = ex_wd;
        w_next.wreg  = ex_wreg;
        w_next.wdata = ex_wdata;
        w_next.hi    = ex_hi;
        w_next.lo    = ex_lo;
        w_next.whilo = ex_whilo;
        w_next.hilo  = '0;
        w_next.cnt   = '0;
      end
      MODE_BUBBLE: begin
        // A NOP goes down to MEM, so neither write enable can be set. The
        // multi-cycle op keeps its scratch state so EX can continue next cycle.
        w_next       = '0;
        w_next.hilo  = hilo_i;
        w_next.cnt   = cnt_i;
      end
      MODE_FLUSH: begin
        w_next       = '0;
      end
      default: begin
        // MODE_HOLD: keep the current contents.
        w_next       = r_stage;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops read
  // their values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
    end else begin
      r_stage <= w_next;
    end
  end

  // Every output comes straight from a flop, with no input-to-output path.
  assign mem_wd    = r_stage.wd;
  assign mem_wreg  = r_stage.wreg;
  assign mem_wdata = r_stage.wdata;
  assign mem_hi    = r_stage.hi;
  assign mem_lo    = r_stage.lo;
  assign mem_whilo = r_stage.whilo;
  assign hilo_o    = r_stage.hilo;
  assign cnt_o     = r_stage.cnt;

endmodule

// File: tb/tb_ex_mem_reg.sv
// -----------------------------------------------------------------------------
// tb_ex_mem_reg -- self-checking testbench for ex_mem_reg
//
// Table-driven vectors. Each record holds the inputs for one clock edge and the
// expected outputs after that edge. Hand-written sequences follow for
// asynchronous reset, the absence of a combinational path and (when built with
// EX_MEM_FLUSH_EN) flush.
// -----------------------------------------------------------------------------
module tb_ex_mem_reg;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } out_t;

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    out_t        exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
`ifdef EX_MEM_FLUSH_EN
  logic        flush;
`endif
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        ex_whilo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int n_checks = 0;
  int n_fails  = 0;

  ex_mem_reg dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
`ifdef EX_MEM_FLUSH_EN
    .flush     (flush),
`endif
    .ex_wd     (ex_wd),
    .ex_wreg   (ex_wreg),
    .ex_wdata  (ex_wdata),
    .ex_hi     (ex_hi),
    .ex_lo     (ex_lo),
    .ex_whilo  (ex_whilo),
    .hilo_i    (hilo_i),
    .cnt_i     (cnt_i),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .mem_whilo (mem_whilo),
    .hilo_o    (hilo_o),
    .cnt_o     (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit, so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic out_t sample();
    out_t o;
    o.wd    = mem_wd;
    o.wreg  = mem_wreg;
    o.wdata = mem_wdata;
    o.hi    = mem_hi;
    o.lo    = mem_lo;
    o.whilo = mem_whilo;
    o.hilo  = hilo_o;
    o.cnt   = cnt_o;
    return o;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got wd=%0d wreg=%b wdata=%h hi=%h lo=%h whilo=%b hilo=%h cnt=%0d, expected wd=%0d wreg=%b wdata=%h hi=%h lo=%h whilo=%b hilo=%h cnt=%0d",
               name, act.wd, act.wreg, act.wdata, act.hi, act.lo, act.whilo, act.hilo, act.cnt,
               exp.wd, exp.wreg, exp.wdata, exp.hi, exp.lo, exp.whilo, exp.hilo, exp.cnt);
    end
  endtask

  task automatic drive(input vec_t v);
    stall    = v.stall;
    ex_wd    = v.wd;
    ex_wreg  = v.wreg;
    ex_wdata = v.wdata;
    ex_hi    = v.hi;
    ex_lo    = v.lo;
    ex_whilo = v.whilo;
    hilo_i   = v.hilo_i;
    cnt_i    = v.cnt_i;
  endtask

  // Drive away from the edge, let one rising edge pass, then sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam out_t ZERO = '0;
  localparam out_t LOAD = '{wd: 5'd9, wreg: 1'b1, wdata: 32'h1234_5678, hi: 32'hA,
                            lo: 32'hB, whilo: 1'b0, hilo: 64'h0, cnt: 2'd0};
  localparam out_t BUB3 = '{wd: 5'd0, wreg: 1'b0, wdata: 32'h0, hi: 32'h0,
                            lo: 32'h0, whilo: 1'b0, hilo: 64'h77, cnt: 2'd3};

  vec_t vecs[12];

  initial begin
    // Sequence from reset. Expected values are worked out by hand from the
    // advance/bubble/hold rules.
    vecs[0]  = '{"advance_basic", 6'b000000, 5'd3, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 64'hAAAA, 2'd2,
                 '{5'd3, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0}};
    vecs[1]  = '{"bubble_first", 6'b001111, 5'd7, 1'b1, 32'h5555, 32'h9, 32'h8, 1'b1, 64'h1_0000_0002, 2'd1,
                 '{5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h1_0000_0002, 2'd1}};
    vecs[2]  = '{"bubble_track", 6'b001000, 5'd7, 1'b1, 32'h6666, 32'h9, 32'h8, 1'b1, 64'h3_0000_0004, 2'd2,
                 '{5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h3_0000_0004, 2'd2}};
    vecs[3]  = '{"advance_after_bubble", 6'b000000, 5'd1, 1'b0, 32'h0, 32'h1, 32'h2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3,
                 '{5'd1, 1'b0, 32'h0, 32'h1, 32'h2, 1'b1, 64'h0, 2'd0}};
    vecs[4]  = '{"advance_load", 6'b000111, 5'd9, 1'b1, 32'h1234_5678, 32'hA, 32'hB, 1'b0, 64'h5, 2'd1, LOAD};
    vecs[5]  = '{"hold_1", 6'b011111, 5'd4, 1'b0, 32'h1111_1111, 32'h3, 32'h4, 1'b1, 64'h9, 2'd2, LOAD};
    vecs[6]  = '{"hold_2", 6'b011111, 5'd5, 1'b1, 32'h2222_2222, 32'h5, 32'h6, 1'b0, 64'hA, 2'd3, LOAD};
    vecs[7]  = '{"hold_3", 6'b011111, 5'd6, 1'b0, 32'h3333_3333, 32'h7, 32'h8, 1'b1, 64'hB, 2'd1, LOAD};
    vecs[8]  = '{"bubble_scratch", 6'b001000, 5'd2, 1'b1, 32'h4444_4444, 32'h1, 32'h1, 1'b1, 64'h77, 2'd3, BUB3};
    vecs[9]  = '{"hold_mem_only", 6'b010000, 5'd8, 1'b1, 32'h8888_8888, 32'h2, 32'h2, 1'b1, 64'h99, 2'd0, BUB3};
    vecs[10] = '{"hold_upper_bit", 6'b110000, 5'd8, 1'b1, 32'h9999_9999, 32'h2, 32'h2, 1'b1, 64'h98, 2'd1, BUB3};
    vecs[11] = '{"advance_max", 6'b100111, 5'd31, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 64'h1, 2'd2,
                 '{5'd31, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 64'h0, 2'd0}};

    // Reset state.
    rst = 1'b1;
`ifdef EX_MEM_FLUSH_EN
    flush = 1'b0;
`endif
    drive('{"idle", 6'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, ZERO});
    #1;
    check("reset_state", sample(), ZERO);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      step();
      check(vecs[i].name, sample(), vecs[i].exp);
    end

    // Inputs changing mid-cycle must not reach the outputs.
    @(negedge clk);
    drive('{"comb", 6'b000000, 5'd12, 1'b0, 32'hCAFE_F00D, 32'h3, 32'h4, 1'b0, 64'h5, 2'd1, ZERO});
    #1;
    check("no_comb_path", sample(),
          '{5'd31, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 64'h0, 2'd0});

    // Asynchronous reset with mem_wreg=1: load it, then assert rst between edges.
    @(negedge clk);
    drive('{"wr", 6'b000000, 5'd3, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0, ZERO});
    step();
    check("pre_reset_wreg", sample(),
          '{5'd3, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0});
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_wreg", sample(), ZERO);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset partway through a multi-cycle op (cnt_o=1).
    @(negedge clk);
    drive('{"mc", 6'b001000, 5'd3, 1'b1, 32'h1, 32'h0, 32'h0, 1'b0, 64'h1_0000_0002, 2'd1, ZERO});
    step();
    check("pre_reset_cnt", sample(),
          '{5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h1_0000_0002, 2'd1});
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_scratch", sample(), ZERO);

    // While reset is held, edges must not load anything, even with Advance inputs.
    drive('{"adv", 6'b000000, 5'd17, 1'b1, 32'hABCD_0123, 32'h5, 32'h6, 1'b1, 64'h0, 2'd0, ZERO});
    step();
    check("reset_held_over_edge", sample(), ZERO);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_released_no_edge", sample(), ZERO);
    step();
    check("first_edge_after_reset", sample(),
          '{5'd17, 1'b1, 32'hABCD_0123, 32'h5, 32'h6, 1'b1, 64'h0, 2'd0});

`ifdef EX_MEM_FLUSH_EN
    // Set up non-zero scratch, then flush while MEM is stalled.
    @(negedge clk);
    drive('{"mc2", 6'b001000, 5'd3, 1'b1, 32'h1, 32'h0, 32'h0, 1'b1, 64'h55, 2'd2, ZERO});
    step();
    @(negedge clk);
    drive('{"fl", 6'b011111, 5'd3, 1'b1, 32'h1, 32'h7, 32'h7, 1'b1, 64'h66, 2'd3, ZERO});
    flush = 1'b1;
    step();
    check("flush_over_hold", sample(), ZERO);
    @(negedge clk);
    flush = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
